// File: rtl/alu_seq_unit.sv
// Handshaked ALU execution unit: single-cycle ops registered, shifts iterate one bit per cycle.
// Optional ALU_SEQ_FAST_SHIFT_EN replaces the iterative shifter with a one-cycle barrel shifter.

`ifndef ALUADD
`define ALUADD  4'd0
`define ALUSUB  4'd1
`define ALUXOR  4'd2
`define ALUOR   4'd3
`define ALUAND  4'd4
`define ALUSLL  4'd5
`define ALUSRL  4'd6
`define ALUSRA  4'd7
`define ALUSLT  4'd8
`define ALUSLTU 4'd9
`endif

module alu_seq_unit #(
    parameter int VAR_WIDTH = 32,
    parameter int OP_WIDTH  = 4,
    parameter int SH_WIDTH  = $clog2(VAR_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OP_WIDTH-1:0]  opcode,
    input  logic [VAR_WIDTH-1:0] a,
    input  logic [VAR_WIDTH-1:0] b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [VAR_WIDTH-1:0] out,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t               state_q, state_d;
    logic [VAR_WIDTH-1:0] out_q, out_d;
    logic [VAR_WIDTH-1:0] alu_res;
    logic [SH_WIDTH-1:0]  shamt;

    assign shamt = b[SH_WIDTH-1:0];

    always_comb begin
        alu_res = '0;
        case (opcode)
            `ALUADD:  alu_res = a + b;
            `ALUSUB:  alu_res = a - b;
            `ALUXOR:  alu_res = a ^ b;
            `ALUOR:   alu_res = a | b;
            `ALUAND:  alu_res = a & b;
            `ALUSLT:  alu_res = {{(VAR_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            `ALUSLTU: alu_res = {{(VAR_WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_SEQ_FAST_SHIFT_EN
            `ALUSLL:  alu_res = a << shamt;
            `ALUSRL:  alu_res = a >> shamt;
            `ALUSRA:  alu_res = $signed(a) >>> shamt;
`endif
            default:  alu_res = '0;
        endcase
    end

`ifndef ALU_SEQ_FAST_SHIFT_EN
    logic [VAR_WIDTH-1:0] work_q, work_d, work_step;
    logic [SH_WIDTH-1:0]  count_q, count_d;
    logic [OP_WIDTH-1:0]  sop_q, sop_d;
    logic                 is_shift;

    assign is_shift = (opcode == `ALUSLL) || (opcode == `ALUSRL) || (opcode == `ALUSRA);

    // One-bit step of the working register; SRA replicates the sign bit.
    always_comb begin
        work_step = {work_q[VAR_WIDTH-2:0], 1'b0};
        if (sop_q == `ALUSRL)
            work_step = {1'b0, work_q[VAR_WIDTH-1:1]};
        else if (sop_q == `ALUSRA)
            work_step = {work_q[VAR_WIDTH-1], work_q[VAR_WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            count_q <= '0;
            sop_q   <= '0;
        end else begin
            work_q  <= work_d;
            count_q <= count_d;
            sop_q   <= sop_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
        work_d    = work_q;
        count_d   = count_q;
        sop_d     = sop_q;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
                    out_d   = alu_res;
                    state_d = RESP;
`else
                    if (is_shift && (shamt != '0)) begin
                        work_d  = a;
                        count_d = shamt;
                        sop_d   = opcode;
                        state_d = SHIFT;
                    end else begin
                        out_d   = is_shift ? a : alu_res;
                        state_d = RESP;
                    end
`endif
                end
            end
            SHIFT: begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
                state_d = IDLE;
`else
                work_d  = work_step;
                count_d = count_q - 1'b1;
                if (count_q == SH_WIDTH'(1)) begin
                    out_d   = work_step;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed testbench for alu_seq_unit: vector table for results/latency plus backpressure and mid-shift reset sequences.
`timescale 1ns/1ps

`ifndef ALUADD
`define ALUADD  4'd0
`define ALUSUB  4'd1
`define ALUXOR  4'd2
`define ALUOR   4'd3
`define ALUAND  4'd4
`define ALUSLL  4'd5
`define ALUSRL  4'd6
`define ALUSRA  4'd7
`define ALUSLT  4'd8
`define ALUSLTU 4'd9
`endif

module tb_alu_seq_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  opcode = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .a(a), .b(b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .out(out), .busy(busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at a negedge after the response is consumed.
    task automatic run_op(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                          output int lat, output logic [31:0] res);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        opcode = op; a = ia; b = ib; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; a = ~ia; b = ~ib; opcode = `ALUAND;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = out;
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL timeout: no rsp_valid after %0d cycles", lat);
        end
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        int          ghost;

        vecs[0]  = '{`ALUADD,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1,  "add_wrap"};
        vecs[1]  = '{`ALUSLT,  32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1,  "slt"};
        vecs[2]  = '{`ALUSLTU, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 1,  "sltu"};
        vecs[3]  = '{`ALUSUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1,  "sub_wrap"};
        vecs[4]  = '{`ALUXOR,  32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1,  "xor"};
        vecs[5]  = '{`ALUOR,   32'hF0F00000, 32'h000000FF, 32'hF0F000FF, 1,  "or"};
        vecs[6]  = '{`ALUAND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1,  "and"};
        vecs[7]  = '{`ALUSRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 32, "sra31"};
        vecs[8]  = '{`ALUSRL,  32'h80000000, 32'h0000001F, 32'h00000001, 32, "srl31"};
        vecs[9]  = '{`ALUSLL,  32'h12345678, 32'h00000020, 32'h12345678, 1,  "sll_masked0"};
        vecs[10] = '{`ALUSLL,  32'h00000001, 32'h00000004, 32'h00000010, 5,  "sll4"};
        vecs[11] = '{`ALUSRA,  32'hF0000000, 32'hFFFFFFE4, 32'hFF000000, 5,  "sra4_hi_bits"};
        vecs[12] = '{`ALUSRL,  32'hF0000000, 32'h00000004, 32'h0F000000, 5,  "srl4"};
        vecs[13] = '{4'hF,     32'h12345678, 32'h87654321, 32'h00000000, 1,  "undef_op"};
        vecs[14] = '{`ALUSLL,  32'h80000001, 32'h00000001, 32'h00000002, 2,  "sll1"};
        vecs[15] = '{`ALUSLT,  32'h00000005, 32'hFFFFFFFF, 32'h00000000, 1,  "slt_neg_b"};

        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].va, vecs[i].vb, lat, res);
            check({vecs[i].name, "_out"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: ADD 3+4 stalled 5 cycles with a second request waiting.
        opcode = `ALUADD; a = 32'd3; b = 32'd4; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        opcode = `ALUAND; a = 32'd6; b = 32'd3;
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_out", out, 32'd7);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_second_out", out, 32'd2);
        @(negedge clk);

        // Reset in the middle of a 20-bit shift.
        opcode = `ALUSLL; a = 32'd1; b = 32'd20; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_out", out, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ghost = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) ghost++;
        end
        check("mid_rst_no_rsp", 32'(ghost), 32'd0);
        run_op(`ALUXOR, 32'hF0F0F0F0, 32'hFFFFFFFF, lat, res);
        check("post_rst_xor_out", res, 32'h0F0F0F0F);
        check("post_rst_xor_lat", 32'(lat), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
